// File: rtl/vslc_spi_pkg.sv
// Shared types and constants for the VSLC SPI target.
package vslc_spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } state_e;

  localparam int unsigned CMD_RW_BIT         = 7;
  localparam int unsigned MIN_SCLK_HALF_CLKS = 4;

endpackage

// File: rtl/vslc_sync_edge.sv
// Multi-stage synchronizer with rise/fall pulses on the synchronized level.
module vslc_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  // Chain resets low so a cs_n held low across reset never looks like a fresh select.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= Stages'({sync_q, d_i});
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/vslc_spi_target.sv
// SPI mode-0 target bridging an external host onto single-cycle register strobes,
// with burst auto-increment and read prefetch.
module vslc_spi_target
  import vslc_spi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  vslc_sync_edge #(.Stages(SYNC_STAGES)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (sclk_i),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  vslc_sync_edge #(.Stages(SYNC_STAGES)) u_sync_cs (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (cs_n_i),
    .q_o    (cs_n_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  vslc_sync_edge #(.Stages(SYNC_STAGES)) u_sync_mosi (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (mosi_i),
    .q_o    (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_s, cs_rise, mosi_rise, mosi_fall};

  state_e            state_q;
  logic [CntW-1:0]   bitcnt_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_wdata_q;
  logic              reg_we_q;
  logic              reg_re_q;
  logic              load_q;
  logic              rw_q;
  logic              busy_q;
  logic              miso_oe_q;

  logic [DATA_W-1:0] rx_byte;
  assign rx_byte = {rx_sr_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      load_q      <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      // Read data is valid one clk after the request; capture it then.
      load_q   <= reg_re_q;
      if (load_q) begin
        tx_sr_q <= reg_rdata_i;
      end
      if (reg_we_q) begin
        reg_addr_q <= reg_addr_q + ADDR_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StCmd;
            bitcnt_q  <= '0;
            busy_q    <= 1'b1;
            miso_oe_q <= 1'b1;
          end
        end
        StCmd: begin
          if (cs_n_s) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + CntW'(1);
            if (bitcnt_q == LastBit) begin
              rw_q       <= rx_byte[CMD_RW_BIT];
              reg_addr_q <= rx_byte[ADDR_W-1:0];
              reg_re_q   <= rx_byte[CMD_RW_BIT];
              state_q    <= StData;
            end
          end
        end
        StData: begin
          if (cs_n_s) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + CntW'(1);
            if (bitcnt_q == LastBit) begin
              if (rw_q) begin
                reg_addr_q <= reg_addr_q + ADDR_W'(1);
                reg_re_q   <= 1'b1;
              end else begin
                reg_wdata_q <= rx_byte;
                reg_we_q    <= 1'b1;
              end
            end
          end else if (sclk_fall && rw_q && (bitcnt_q != '0)) begin
            // The first fall of each byte only presents the MSB; later falls advance.
            tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign miso_o      = (state_q == StData) && rw_q && tx_sr_q[DATA_W-1];
  assign miso_oe_o   = miso_oe_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_vslc_spi_target.sv
// Self-checking bench for vslc_spi_target: SPI host model, register responder and
// a transaction-level register model.
`timescale 1ns/1ps
module tb_vslc_spi_target;
  import vslc_spi_pkg::*;

  logic       clk, rst, sclk, cs_n, mosi;
  logic       miso, miso_oe, reg_we, reg_re, busy;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  regs     [128];
  logic [7:0]  exp_regs [128];
  logic [7:0]  tx_buf   [32];
  logic [7:0]  rx_buf   [32];
  logic [14:0] we_log   [$];
  logic [6:0]  re_log   [$];

  vslc_spi_target dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sclk_i      (sclk),
    .cs_n_i      (cs_n),
    .mosi_i      (mosi),
    .miso_o      (miso),
    .miso_oe_o   (miso_oe),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_we_o    (reg_we),
    .reg_re_o    (reg_re),
    .reg_rdata_i (reg_rdata),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register peripheral: data valid exactly one clk after reg_re, noise otherwise.
  always @(posedge clk) reg_rdata <= reg_re ? regs[reg_addr] : 8'($urandom);

  always @(negedge clk) begin
    if (reg_we || reg_re) begin
      checks++;
      if (reg_we && reg_re) begin
        errors++;
        $display("FAIL strobe_overlap: we=%b re=%b, required not both high", reg_we, reg_re);
      end
    end
    if (reg_we) begin
      we_log.push_back({reg_addr, reg_wdata});
      regs[reg_addr] = reg_wdata;
    end
    if (reg_re) re_log.push_back(reg_addr);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic spi_bits(input logic [7:0] tx, input int nb, input int h,
                          output logic [7:0] rx);
    rx = '0;
    for (int k = 0; k < nb; k++) begin
      mosi = tx[7-k];
      repeat (h) @(negedge clk);
      sclk = 1'b1;
      rx[7-k] = miso;
      repeat (h) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int n, input int h);
    logic [7:0] rx;
    we_log.delete();
    re_log.delete();
    @(negedge clk);
    cs_n = 1'b0;
    spi_bits(cmd, 8, h, rx);
    for (int i = 0; i < n; i++) begin
      spi_bits(tx_buf[i], 8, h, rx);
      rx_buf[i] = rx;
    end
    repeat (h) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso, miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {miso, miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, miso_oe, reg_we, reg_re} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy/oe/we/re=%b, required 0000",
               {busy, miso_oe, reg_we, reg_re});
    end
  endtask

  task automatic test_write(input logic [6:0] a, input int n, input int h);
    for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
    run_txn({1'b0, a}, n, h);
    for (int i = 0; i < n; i++) exp_regs[7'(a + i)] = tx_buf[i];
    checks++;
    if (we_log.size() != n || re_log.size() != 0) begin
      errors++;
      $display("FAIL write_count a=%h: we=%0d re=%0d, required we=%0d re=0",
               a, we_log.size(), re_log.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (we_log[i] !== {7'(a + i), tx_buf[i]}) begin
          errors++;
          $display("FAIL write_data byte %0d: got addr/data %h, required %h",
                   i, we_log[i], {7'(a + i), tx_buf[i]});
        end
      end
    end
  endtask

  task automatic test_read(input logic [6:0] a, input int n, input int h);
    for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
    run_txn({1'b1, a}, n, h);
    checks++;
    if (re_log.size() != n + 1 || we_log.size() != 0) begin
      errors++;
      $display("FAIL read_count a=%h: re=%0d we=%0d, required re=%0d we=0",
               a, re_log.size(), we_log.size(), n + 1);
    end else begin
      for (int i = 0; i <= n; i++) begin
        checks++;
        if (re_log[i] !== 7'(a + i)) begin
          errors++;
          $display("FAIL read_addr %0d: got %h, required %h", i, re_log[i], 7'(a + i));
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_buf[i] !== exp_regs[7'(a + i)]) begin
        errors++;
        $display("FAIL read_miso a=%h byte %0d: got %h, required %h",
                 a, i, rx_buf[i], exp_regs[7'(a + i)]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    we_log.delete();
    @(negedge clk);
    cs_n = 1'b0;
    spi_bits(8'h10, 8, 5, rx);
    spi_bits(8'hFF, 5, 5, rx);
    checks++;
    if ({busy, miso_oe, miso} !== 3'b110) begin
      errors++;
      $display("FAIL abort_active: busy/oe/miso=%b, required 110", {busy, miso_oe, miso});
    end
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, miso_oe} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: busy/oe=%b, required 00", {busy, miso_oe});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (we_log.size() != 0) begin
      errors++;
      $display("FAIL abort_no_write: %0d writes, required 0", we_log.size());
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] rx;
    @(negedge clk);
    cs_n = 1'b0;
    spi_bits(8'hC0, 8, 5, rx);
    spi_bits(8'h00, 8, 5, rx);
    spi_bits(8'h00, 3, 5, rx);
    checks++;
    if ({busy, miso_oe, reg_addr} !== {2'b11, 7'h41}) begin
      errors++;
      $display("FAIL rst_pre: busy/oe/addr=%h, required %h", {busy, miso_oe, reg_addr},
               {2'b11, 7'h41});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({miso, miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy} !== '0) begin
      errors++;
      $display("FAIL rst_async: outputs %h, required 0",
               {miso, miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    we_log.delete();
    re_log.delete();
    spi_bits(8'h82, 8, 5, rx);
    checks++;
    if (busy !== 1'b0 || we_log.size() != 0 || re_log.size() != 0) begin
      errors++;
      $display("FAIL rst_no_restart: busy=%b we=%0d re=%0d, required 0/0/0",
               busy, we_log.size(), re_log.size());
    end
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    tx_buf[0] = 8'h01;
    run_txn(8'h02, 1, 5);
    exp_regs[2] = 8'h01;
    checks++;
    if (we_log.size() != 1 || re_log.size() != 0) begin
      errors++;
      $display("FAIL rst_recover_count: we=%0d re=%0d, required 1/0",
               we_log.size(), re_log.size());
    end else begin
      checks++;
      if (we_log[0] !== {7'h02, 8'h01}) begin
        errors++;
        $display("FAIL rst_recover_data: got %h, required %h", we_log[0], {7'h02, 8'h01});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a;
    a = 7'($urandom);
    for (int i = 0; i < 16; i++) begin
      regs[7'(a + i)]     = (i % 2 == 0) ? 8'hFF : 8'h00;
      exp_regs[7'(a + i)] = regs[7'(a + i)];
    end
    test_read(a, 16, MIN_SCLK_HALF_CLKS);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      regs[i]     = 8'($urandom);
      exp_regs[i] = regs[i];
    end
    test_reset();
    // Directed cases
    tx_buf[0] = 8'hA5;
    run_txn(8'h05, 1, 5);
    exp_regs[5] = 8'hA5;
    checks++;
    if (we_log.size() != 1 || re_log.size() != 0 || we_log[0] !== {7'h05, 8'hA5}) begin
      errors++;
      $display("FAIL write_basic: we=%0d re=%0d first=%h, required 1/0/%h",
               we_log.size(), re_log.size(), (we_log.size() > 0) ? we_log[0] : 15'h0,
               {7'h05, 8'hA5});
    end
    regs[5]     = 8'h3C;
    exp_regs[5] = 8'h3C;
    test_read(7'h05, 1, 4);
    tx_buf[0] = 8'h11;
    tx_buf[1] = 8'h22;
    run_txn(8'h7F, 2, 5);
    exp_regs[7'h7F] = 8'h11;
    exp_regs[7'h00] = 8'h22;
    checks++;
    if (we_log.size() != 2 || we_log[0] !== {7'h7F, 8'h11} || we_log[1] !== {7'h00, 8'h22}) begin
      errors++;
      $display("FAIL burst_wrap: %0d writes, first two %h %h, required %h %h",
               we_log.size(), (we_log.size() > 0) ? we_log[0] : 15'h0,
               (we_log.size() > 1) ? we_log[1] : 15'h0, {7'h7F, 8'h11}, {7'h00, 8'h22});
    end
    test_read(7'h7F, 2, 4);
    test_abort();
    test_async_reset();
    // Randomized traffic against the register model
    for (int t = 0; t < 4; t++) begin
      test_write(7'($urandom), $urandom_range(1, 3), $urandom_range(4, 6));
      test_read(7'($urandom), $urandom_range(1, 4), $urandom_range(4, 6));
    end
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vslc_spi_target.md
Name: vslc_spi_target

Overview:
- SPI mode-0 responder that gives an external host register access to the VSLC core (program/IO image, timer presets).
- It is the other end of the core's SPI initiator. The core masters program fetch; this block lets a host master the chip.
- All SPI pins are oversampled in the system clock domain and converted into a single-cycle register read/write strobe interface.
- Supports burst transfers with address auto-increment.

Parameters:
- ADDR_W, 7, register address width; the command byte is {rw, addr[6:0]}.
- DATA_W, 8, data word width; fixed at 8 for this revision.
- SYNC_STAGES, 2, flip-flop stages on sclk, cs_n and mosi.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock from host, idle low (mode 0)
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  host-to-target data, MSB first
- miso  out  1  target-to-host data, MSB first
- miso_oe  out  1  output enable for miso pad
- reg_addr  out  ADDR_W  register address for the current access
- reg_wdata  out  DATA_W  write data, valid while reg_we is high
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read request
- reg_rdata  in  DATA_W  read data, valid one clk after reg_re
- busy  out  1  high while a transaction is in progress (cs_n asserted, synchronized)

Behaviour:
- Reset values: all outputs 0; state IDLE; shift registers 0; bit counter 0.
- Clock ratio requirement: sclk high and low phases are each at least 4 clk periods, i.e. f_sclk ≤ f_clk/8. Operation outside this limit is not supported.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flip-flops. Rising and falling sclk edges are detected on the synchronized signal. mosi is sampled on the detected rising edge.
- State IDLE:
  - miso_oe=0, miso=0, busy=0.
  - Synchronized cs_n falling -> CMD, with bitcnt=0 and busy=1.
- State CMD:
  - Shift mosi into cmd_sr on each rising edge.
  - On the 8th bit: latch rw=bit7 and addr=bits6:0; reg_addr<=addr.
  - rw=1 (read): pulse reg_re the following clk; capture reg_rdata into tx_sr one clk after reg_re. Go to DATA.
  - rw=0 (write): go to DATA.
- State DATA:
  - Shift mosi into rx_sr on each rising edge.
  - On a read, miso drives tx_sr MSB. tx_sr shifts on each falling edge.
  - The first data bit (MSB) is driven on the falling edge immediately after the 8th command bit.
  - After 8 data bits on a write: reg_wdata<=rx_sr and reg_we pulses one clk with the current reg_addr.
  - After 8 data bits on a read: no write occurs.
  - In both cases reg_addr then increments, wrapping from 2^ADDR_W-1 to 0.
  - On a read the increment also issues a new reg_re (prefetch), and the result loads into tx_sr before the next falling edge.
  - Remain in DATA for further bytes.
- miso_oe is 1 in CMD and DATA; miso is 0 while in CMD.
- cs_n deasserted (synchronized high) in any state:
  - Go to IDLE the next clk.
  - Discard any partial byte: no reg_we. A completed byte whose reg_we was already issued stands.
  - miso_oe drops the same clk IDLE is entered.
- Simultaneous cs_n rise and sclk edge detected in the same clk: cs_n wins and the edge is ignored.
- reg_we and reg_re are never high in the same cycle.
- Burst behaviour: a read burst issues exactly one reg_re per byte, including a final prefetch that the host may not clock out.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The next transfer starts only on a fresh cs_n falling edge.

Decomposition:
- Shared package vslc_spi_pkg contains:
  - state enum {IDLE, CMD, DATA}
  - CMD_RW_BIT=7
  - MIN_SCLK_HALF_CLKS=4
- Sub-module vslc_sync_edge, instantiated three times:
  - parameterized synchronizer with rise/fall pulse outputs for sclk and cs_n
  - level output only for mosi

Test Plan:
- Write: cs_n low, send 0x05 then 0xA5, cs_n high -> single reg_we with reg_addr=0x05 and reg_wdata=0xA5; no reg_re.
- Read: send 0x85, host clocks 8 more bits; reg_rdata returns 0x3C for addr 0x05 -> reg_re pulses once with addr 0x05; host shifts in 0x3C on miso.
- Burst write wrap: send 0x7F, then 0x11, 0x22 -> reg_we at addr 0x7F with 0x11, then at addr 0x00 with 0x22.
- Abort: send 0x10, then 5 data bits, cs_n high -> no reg_we; busy=0 and miso_oe=0 within SYNC_STAGES+1 clks.
- Async reset: assert rst mid-read-burst -> all outputs 0 immediately. Next transaction writing 0x01 at addr 0x02 completes normally.
- Clock-ratio corner: sclk half period exactly 4 clk on a read of 0xFF/0x00 alternating addresses -> no bit errors over 16 bytes.
